// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin arbiter that multiplexes NumIn valid/ready sources onto one CDC FIFO write port.
// Each beat is tagged with the winner's index. Optionally, a packet holds the grant until its last beat.
module cdc_fifo_src_arbiter #(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned WIDTH       = 1,
  parameter type         T           = logic [WIDTH-1:0],
  parameter bit          LockPackets = 1'b1,
  parameter int unsigned IdxWidth    = (NumIn > 1) ? $clog2(NumIn) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  T [NumIn-1:0]        req_data_i,
  input  logic [NumIn-1:0]    req_last_i,
  input  logic [NumIn-1:0]    req_valid_i,
  output logic [NumIn-1:0]    req_ready_o,
  output T                    fifo_data_o,
  output logic [IdxWidth-1:0] fifo_idx_o,
  output logic                fifo_last_o,
  output logic                fifo_valid_o,
  input  logic                fifo_ready_i,
  output logic                idle_o,
  output logic [1:0]          dbg_state_o
);

  // Handshake: a beat moves on a clock edge when fifo_valid_o and fifo_ready_i are both high.
  // Only the granted requester sees ready. Once valid is shown, it is never withdrawn or
  // changed until accepted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    LOCK = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IdxWidth-1:0] rr_q, rr_d;
  logic [IdxWidth-1:0] gnt_q, gnt_d;
  logic [IdxWidth-1:0] arb_idx;
  logic [IdxWidth-1:0] scan_idx;
  logic [IdxWidth-1:0] gnt;
  logic                arb_found;
  logic                active;
  logic                hs;
  logic                last_eff;
  int                  scan;

  function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] i);
    if (int'(i) >= int'(NumIn) - 1) return '0;
    return i + 1'b1;
  endfunction

  // Priority scan starting at rr_q, wrapping from NumIn-1 back to 0
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int i = 0; i < int'(NumIn); i++) begin
      scan = int'(rr_q) + i;
      if (scan >= int'(NumIn)) scan = scan - int'(NumIn);
      scan_idx = IdxWidth'(scan);
      if (!arb_found && req_valid_i[scan_idx]) begin
        arb_found = 1'b1;
        arb_idx   = scan_idx;
      end
    end
  end

  // A shown-but-unaccepted beat freezes the grant, so later arrivals cannot preempt it
  assign gnt = (state_q == IDLE) ? arb_idx : gnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
    end
  end

  always_comb begin
    hs       = fifo_valid_o && fifo_ready_i;
    last_eff = fifo_last_o || !LockPackets;
    state_d  = state_q;
    rr_d     = rr_q;
    gnt_d    = gnt_q;
    case (state_q)
      IDLE: begin
        if (arb_found) begin
          if (!fifo_ready_i) begin
            state_d = HOLD;
            gnt_d   = gnt;
          end else if (last_eff) begin
            rr_d = wrap_inc(gnt);
          end else begin
            state_d = LOCK;
            gnt_d   = gnt;
          end
        end
      end
      HOLD: begin
        if (hs) begin
          if (last_eff) begin
            state_d = IDLE;
            rr_d    = wrap_inc(gnt_q);
          end else begin
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        if (hs && last_eff) begin
          state_d = IDLE;
          rr_d    = wrap_inc(gnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even if requesters are still valid
  always_comb begin
    req_ready_o  = '0;
    active       = rst_ni && ((state_q != IDLE) || arb_found);
    fifo_valid_o = rst_ni && req_valid_i[gnt];
    if (active) req_ready_o[gnt] = fifo_ready_i;
    fifo_data_o  = req_data_i[gnt];
    fifo_idx_o   = gnt;
    fifo_last_o  = req_last_i[gnt];
    idle_o       = (state_q == IDLE) && !(|req_valid_i);
    dbg_state_o  = state_q;
  end

  a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));

  a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (fifo_valid_o && !fifo_ready_i) |=>
      (fifo_valid_o && $stable(fifo_data_o) && $stable(fifo_idx_o)));

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Directed bench for cdc_fifo_src_arbiter. Two instances share the same stimulus:
// one arbitrates per beat, the other holds the grant for whole packets.
module tb_cdc_fifo_src_arbiter;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_LOCK = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0][7:0] req_data;
  logic [3:0]      req_last;
  logic [3:0]      req_valid;
  logic            fifo_ready;

  logic [3:0] rr_ready, lk_ready;
  logic [7:0] rr_data, lk_data;
  logic [1:0] rr_idx, lk_idx, rr_state, lk_state;
  logic       rr_last, lk_last, rr_valid, lk_valid, rr_idle, lk_idle;

  cdc_fifo_src_arbiter #(.NumIn(4), .WIDTH(8), .LockPackets(1'b0)) dut_rr (
    .clk_i(clk), .rst_ni(rst_n), .req_data_i(req_data), .req_last_i(req_last),
    .req_valid_i(req_valid), .req_ready_o(rr_ready), .fifo_data_o(rr_data),
    .fifo_idx_o(rr_idx), .fifo_last_o(rr_last), .fifo_valid_o(rr_valid),
    .fifo_ready_i(fifo_ready), .idle_o(rr_idle), .dbg_state_o(rr_state)
  );

  cdc_fifo_src_arbiter #(.NumIn(4), .WIDTH(8), .LockPackets(1'b1)) dut_lk (
    .clk_i(clk), .rst_ni(rst_n), .req_data_i(req_data), .req_last_i(req_last),
    .req_valid_i(req_valid), .req_ready_o(lk_ready), .fifo_data_o(lk_data),
    .fifo_idx_o(lk_idx), .fifo_last_o(lk_last), .fifo_valid_o(lk_valid),
    .fifo_ready_i(fifo_ready), .idle_o(lk_idle), .dbg_state_o(lk_state)
  );

  int total = 0;
  int bad = 0;

  // scoreboard primitives
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk(input string tag, input bit sel, input logic efv, input logic [3:0] er,
                     input logic [1:0] ei, input logic [7:0] ed, input logic el,
                     input logic eidle, input logic [1:0] est);
    logic       afv, alast, aidle;
    logic [3:0] ar;
    logic [1:0] ai, ast;
    logic [7:0] ad;
    afv   = sel ? lk_valid : rr_valid;
    ar    = sel ? lk_ready : rr_ready;
    ai    = sel ? lk_idx   : rr_idx;
    ad    = sel ? lk_data  : rr_data;
    alast = sel ? lk_last  : rr_last;
    aidle = sel ? lk_idle  : rr_idle;
    ast   = sel ? lk_state : rr_state;
    cmp({tag, ".valid"}, 32'(afv), 32'(efv));
    cmp({tag, ".ready"}, 32'(ar), 32'(er));
    cmp({tag, ".idle"}, 32'(aidle), 32'(eidle));
    cmp({tag, ".state"}, 32'(ast), 32'(est));
    if (efv) begin
      cmp({tag, ".idx"}, 32'(ai), 32'(ei));
      cmp({tag, ".data"}, 32'(ad), 32'(ed));
      cmp({tag, ".last"}, 32'(alast), 32'(el));
    end
  endtask

  // driver: inputs change just after the rising edge, outputs are checked at the falling edge
  task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] l,
                       input logic r, input logic [7:0] d2);
    @(posedge clk);
    #1;
    rst_n       = rst;
    req_valid   = v;
    req_last    = l;
    fifo_ready  = r;
    req_data[2] = d2;
    @(negedge clk);
  endtask

  typedef struct {
    logic [3:0] valid;
    logic       rdy;
    logic       exp_fv;
    logic [3:0] exp_r;
    logic [1:0] exp_idx;
    logic       exp_idle;
    logic [1:0] exp_st;
  } vec_t;

  vec_t tbl[17];

  initial begin
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    req_last  = 4'b1111;
    req_valid = 4'b0000;
    fifo_ready = 1'b0;

    // reset idle, then round robin with every requester valid, then a stall with a late arrival
    tbl[0] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, S_IDLE};
    for (int k = 0; k < 8; k++)
      tbl[1 + k] = '{4'b1111, 1'b1, 1'b1, 4'(1 << (k % 4)), 2'(k % 4), 1'b0, S_IDLE};
    tbl[9]  = '{4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, S_IDLE};
    tbl[10] = '{4'b0010, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, S_HOLD};
    tbl[11] = '{4'b0011, 1'b0, 1'b1, 4'b0000, 2'd1, 1'b0, S_HOLD};
    tbl[12] = '{4'b0011, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, S_HOLD};
    tbl[13] = '{4'b0001, 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0, S_IDLE};
    tbl[14] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b1, S_IDLE};
    tbl[15] = '{4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b0, S_IDLE};
    tbl[16] = '{4'b0110, 1'b1, 1'b1, 4'b0010, 2'd1, 1'b0, S_IDLE};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rr", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b1, S_IDLE);
    chk("rst_lk", 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b1, S_IDLE);

    for (int i = 0; i < 17; i++) begin
      drive(1'b1, tbl[i].valid, 4'b1111, tbl[i].rdy, 8'hA2);
      chk($sformatf("tbl%0d_rr", i), 1'b0, tbl[i].exp_fv, tbl[i].exp_r, tbl[i].exp_idx,
          8'hA0 + 8'(tbl[i].exp_idx), 1'b1, tbl[i].exp_idle, tbl[i].exp_st);
      chk($sformatf("tbl%0d_lk", i), 1'b1, tbl[i].exp_fv, tbl[i].exp_r, tbl[i].exp_idx,
          8'hA0 + 8'(tbl[i].exp_idx), 1'b1, tbl[i].exp_idle, tbl[i].exp_st);
    end

    // 3-beat packet from req2 with a bubble and a stall; req0 waits throughout (rr_ptr=2 here)
    drive(1'b1, 4'b0101, 4'b1011, 1'b1, 8'h21);
    chk("pk1_lk", 1'b1, 1'b1, 4'b0100, 2'd2, 8'h21, 1'b0, 1'b0, S_IDLE);
    chk("pk1_rr", 1'b0, 1'b1, 4'b0100, 2'd2, 8'h21, 1'b0, 1'b0, S_IDLE);
    drive(1'b1, 4'b0001, 4'b1011, 1'b1, 8'h21);
    chk("bub_lk", 1'b1, 1'b0, 4'b0100, 2'd2, 8'h21, 1'b0, 1'b0, S_LOCK);
    chk("bub_rr", 1'b0, 1'b1, 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b0, S_IDLE);
    drive(1'b1, 4'b0101, 4'b1011, 1'b1, 8'h22);
    chk("pk2_lk", 1'b1, 1'b1, 4'b0100, 2'd2, 8'h22, 1'b0, 1'b0, S_LOCK);
    chk("pk2_rr", 1'b0, 1'b1, 4'b0100, 2'd2, 8'h22, 1'b0, 1'b0, S_IDLE);
    drive(1'b1, 4'b0101, 4'b1111, 1'b0, 8'h23);
    chk("full_lk", 1'b1, 1'b1, 4'b0000, 2'd2, 8'h23, 1'b1, 1'b0, S_LOCK);
    chk("full_rr", 1'b0, 1'b1, 4'b0000, 2'd0, 8'hA0, 1'b1, 1'b0, S_IDLE);
    drive(1'b1, 4'b0101, 4'b1111, 1'b1, 8'h23);
    chk("pk3_lk", 1'b1, 1'b1, 4'b0100, 2'd2, 8'h23, 1'b1, 1'b0, S_LOCK);
    chk("pk3_rr", 1'b0, 1'b1, 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b0, S_HOLD);
    drive(1'b1, 4'b0001, 4'b1111, 1'b1, 8'h23);
    chk("after_lk", 1'b1, 1'b1, 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b0, S_IDLE);
    chk("after_rr", 1'b0, 1'b1, 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b0, S_IDLE);
    drive(1'b1, 4'b0000, 4'b1111, 1'b1, 8'h23);
    chk("quiet_lk", 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b1, S_IDLE);
    chk("quiet_rr", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b1, S_IDLE);

    // reset while the locking instance is mid-packet
    drive(1'b1, 4'b0010, 4'b1101, 1'b1, 8'h23);
    chk("mp1_lk", 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1, 1'b0, 1'b0, S_IDLE);
    chk("mp1_rr", 1'b0, 1'b1, 4'b0010, 2'd1, 8'hA1, 1'b0, 1'b0, S_IDLE);
    drive(1'b1, 4'b0010, 4'b1101, 1'b1, 8'h23);
    chk("mp2_lk", 1'b1, 1'b1, 4'b0010, 2'd1, 8'hA1, 1'b0, 1'b0, S_LOCK);
    chk("mp2_rr", 1'b0, 1'b1, 4'b0010, 2'd1, 8'hA1, 1'b0, 1'b0, S_IDLE);
    drive(1'b0, 4'b0010, 4'b1101, 1'b1, 8'h23);
    chk("inrst_lk", 1'b1, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0, S_IDLE);
    chk("inrst_rr", 1'b0, 1'b0, 4'b0000, 2'd0, 8'h00, 1'b0, 1'b0, S_IDLE);
    drive(1'b1, 4'b0101, 4'b1111, 1'b1, 8'hA2);
    chk("rel_lk", 1'b1, 1'b1, 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b0, S_IDLE);
    chk("rel_rr", 1'b0, 1'b1, 4'b0001, 2'd0, 8'hA0, 1'b1, 1'b0, S_IDLE);
    drive(1'b1, 4'b0100, 4'b1111, 1'b1, 8'hA2);
    chk("rel2_lk", 1'b1, 1'b1, 4'b0100, 2'd2, 8'hA2, 1'b1, 1'b0, S_IDLE);
    chk("rel2_rr", 1'b0, 1'b1, 4'b0100, 2'd2, 8'hA2, 1'b1, 1'b0, S_IDLE);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
